// File: rtl/testio_req_queue.sv
// Test-IO request queue: buffers upstream requests in a FIFO and issues them one at a
// time to a single-outstanding serial master, with response timeout and stray accounting.

package testio_req_queue_pkg;
  localparam int unsigned REQ_W  = 87;
  localparam int unsigned RESP_W = 51;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] tid;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } ti_req_t;

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] tid;
    logic [31:0] rdata;
  } ti_resp_t;
endpackage

module testio_req_queue
  import testio_req_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic              ti_clk_i,
  input  logic              ti_rst_i,
  input  logic              up_req_valid,
  output logic              up_req_ready,
  input  logic [REQ_W-1:0]  up_req,
  output logic              up_resp_valid,
  input  logic              up_resp_ready,
  output logic [RESP_W-1:0] up_resp,
  output logic              dn_req_valid,
  input  logic              dn_req_ready,
  output logic [REQ_W-1:0]  dn_req,
  input  logic              dn_resp_valid,
  output logic              dn_resp_ready,
  input  logic [RESP_W-1:0] dn_resp,
  output logic [7:0]        err_cnt,
  output logic [7:0]        stray_cnt,
  output logic              busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    CNT_MAX    = 8'hFF;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR_RESP} state_e;

  state_e        state_q, state_d;
  ti_req_t       mem_q [DEPTH];
  ti_req_t       head;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    kind_q;
  logic [15:0]   tid_q;
  logic          push, pop;
  ti_resp_t      up_resp_q, up_resp_d;
  ti_req_t       dn_req_q, dn_req_d;
  logic [7:0]    err_cnt_d, stray_cnt_d;

  assign head          = mem_q[rd_ptr_q];
  assign push          = up_req_valid && up_req_ready;
  assign pop           = (state_q == ISSUE) && dn_req_ready;
  assign count_d       = count_q + CW'(push) - CW'(pop);
  assign dn_resp_ready = 1'b1;
  assign up_resp       = up_resp_q;
  assign dn_req        = dn_req_q;

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge ti_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ti_req_t'(up_req);
    end
  end

  // Next state and timer
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = ISSUE;
      end
      ISSUE: begin
        if (dn_req_ready) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // a response arriving in the final timer cycle still wins over the timeout
        if (dn_resp_valid) begin
          state_d = RESP;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ERR_RESP;
        end
      end
      RESP, ERR_RESP: begin
        if (up_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered payloads and counters
  always_comb begin
    up_resp_d   = '0;
    dn_req_d    = '0;
    err_cnt_d   = err_cnt;
    stray_cnt_d = stray_cnt;
    case (state_d)
      ISSUE:    dn_req_d  = head;
      RESP:     up_resp_d = (state_q == WAIT) ? ti_resp_t'(dn_resp) : up_resp_q;
      ERR_RESP: up_resp_d = (state_q == WAIT) ? ti_resp_t'({kind_q, tid_q, ERR_DATA}) : up_resp_q;
      default:  ;
    endcase
    if ((state_d == ERR_RESP) && (state_q == WAIT) && (err_cnt != CNT_MAX)) begin
      err_cnt_d = err_cnt + 8'd1;
    end
    if (dn_resp_valid && (state_q != WAIT) && (stray_cnt != CNT_MAX)) begin
      stray_cnt_d = stray_cnt + 8'd1;
    end
  end

  // State, pointers and registered outputs
  always_ff @(posedge ti_clk_i) begin
    if (ti_rst_i) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      kind_q        <= '0;
      tid_q         <= '0;
      up_resp_q     <= '0;
      dn_req_q      <= '0;
      up_req_ready  <= 1'b1;
      up_resp_valid <= 1'b0;
      dn_req_valid  <= 1'b0;
      busy          <= 1'b0;
      err_cnt       <= '0;
      stray_cnt     <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        kind_q   <= head.kind;
        tid_q    <= head.tid;
      end
      up_resp_q     <= up_resp_d;
      dn_req_q      <= dn_req_d;
      up_req_ready  <= (count_d != FULL_CNT);
      up_resp_valid <= (state_d == RESP) || (state_d == ERR_RESP);
      dn_req_valid  <= (state_d == ISSUE);
      busy          <= (count_d != '0) || (state_d != IDLE);
      err_cnt       <= err_cnt_d;
      stray_cnt     <= stray_cnt_d;
    end
  end

endmodule
